// File: rtl/snd_dc_filter.sv
// Sound post-processing: samples an 8-bit unsigned core sound byte, removes DC with a
// leaky high-pass, smooths with a one-pole low-pass and emits a saturated signed 16-bit sample.
module snd_dc_filter #(
  parameter int unsigned CLK_DIV  = 512,
  parameter int unsigned HP_SHIFT = 10,
  parameter int unsigned LP_SHIFT = 2,
  parameter int unsigned ACC_W    = 24
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [7:0]         snd_in,
  input  logic               bypass,
  input  logic               mute,
  output logic signed [15:0] audio_out,
  output logic               audio_vld
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned SumW = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] SatHi = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SatLo = ACC_W'(-32768);

  logic [CntW-1:0] div_q;
  logic            stb;

  // S1 registers
  logic                    s1_vld_q;
  logic signed [ACC_W-1:0] x_q;
  logic                    byp1_q;
  logic                    mute1_q;

  // S2 registers and filter state
  logic                    s2_vld_q;
  logic                    byp2_q;
  logic                    mute2_q;
  logic signed [ACC_W-1:0] xp_q;
  logic signed [ACC_W-1:0] y_q;
  logic signed [ACC_W-1:0] z_q;

  logic signed [15:0]      x16;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] y_shr;
  logic signed [SumW-1:0]  y_sum;
  logic signed [ACC_W-1:0] y_new;
  logic signed [SumW-1:0]  zd;
  logic signed [SumW-1:0]  zd_shr;
  logic signed [SumW-1:0]  z_sum;
  logic signed [ACC_W-1:0] z_new;
  logic signed [ACC_W-1:0] src;
  logic signed [15:0]      sat;
  logic                    unused_sum_msb;

  assign stb = (div_q == CntW'(CLK_DIV - 1));

  always_comb begin
    // Offset-binary to two's complement, left-justified to 16 bits
    x16    = {~snd_in[7], snd_in[6:0], 8'h00};
    x_ext  = {{(ACC_W - 16){x16[15]}}, x16};

    y_shr  = y_q >>> HP_SHIFT;
    y_sum  = SumW'(x_q) - SumW'(xp_q) + SumW'(y_q) - SumW'(y_shr);
    y_new  = y_sum[ACC_W-1:0];

    zd     = SumW'(y_q) - SumW'(z_q);
    zd_shr = zd >>> LP_SHIFT;
    z_sum  = SumW'(z_q) + zd_shr;
    z_new  = z_sum[ACC_W-1:0];

    // In S3 xp_q already holds this sample's x
    src    = byp2_q ? xp_q : z_new;
    if (src > SatHi) begin
      sat = 16'sh7fff;
    end else if (src < SatLo) begin
      sat = -16'sh8000;
    end else begin
      sat = src[15:0];
    end
  end

  assign unused_sum_msb = ^{y_sum[ACC_W], z_sum[ACC_W]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q     <= '0;
      s1_vld_q  <= 1'b0;
      x_q       <= '0;
      byp1_q    <= 1'b0;
      mute1_q   <= 1'b0;
      s2_vld_q  <= 1'b0;
      byp2_q    <= 1'b0;
      mute2_q   <= 1'b0;
      xp_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      audio_out <= '0;
      audio_vld <= 1'b0;
    end else begin
      div_q <= stb ? '0 : div_q + 1'b1;

      s1_vld_q <= stb;
      if (stb) begin
        x_q     <= x_ext;
        byp1_q  <= bypass;
        mute1_q <= mute;
      end

      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        xp_q    <= x_q;
        y_q     <= y_new;
        byp2_q  <= byp1_q;
        mute2_q <= mute1_q;
      end

      audio_vld <= s2_vld_q;
      if (s2_vld_q) begin
        z_q       <= z_new;
        audio_out <= mute2_q ? 16'sh0000 : sat;
      end
    end
  end

endmodule
